pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Unified hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Combines four functions:
  - operand forwarding selects for the EX-stage mux4 operand muxes;
  - load-use stall/bubble;
  - branch/jump redirect flush;
  - variable-latency data-memory wait, using a req/ready handshake with timeout detection.
- Adds saturating performance counters for stall cycles and flushes.
- Sits beside the datapath. Its outputs drive the PC enable, the IF/ID and ID/EX stall/flush controls, and the EX/MEM and MEM/WB hold/bubble controls.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, performance counter width.
- MEM_TIMEOUT, 64, memory-wait cycles before mem_err is raised (must be ≥1).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  REG_ADDR_W  source registers of the instruction in EX.
- ex_rd, ex_reg_write, ex_mem_read  in  REG_ADDR_W/1/1  destination and controls of the instruction in EX.
- mem_rd, mem_reg_write  in  REG_ADDR_W/1  destination and write enable of the instruction in MEM.
- mem_req  in  1  the MEM stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_rd, wb_reg_write  in  REG_ADDR_W/1  destination and write enable of the instruction in WB.
- br_taken  in  1  redirect resolved in EX (taken branch, jal, jalr).
- fwd_a, fwd_b  out  2  operand selects: 00 register file, 01 EX/MEM ALU result, 10 WB data.
- stall_pc, stall_if_id  out  1  hold the PC and IF/ID register.
- bubble_id_ex  out  1  load zeros (NOP controls) into ID/EX.
- flush_if_id, flush_id_ex  out  1  redirect flush of IF/ID and ID/EX.
- hold_ex  out  1  freeze ID/EX and EX/MEM (memory wait).
- bubble_mem_wb  out  1  load NOP into MEM/WB (memory wait).
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles, flush_count  out  CNT_W  performance counters.

Behaviour:
- Internal term mem_stall = mem_req & ~mem_ready. This term is combinational and valid in any FSM state.
- Internal term load_use = ex_mem_read & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Control priority, highest first; at most one row is active per cycle:
  - (1) mem_stall: stall_pc = stall_if_id = hold_ex = bubble_mem_wb = 1. Flush outputs, bubble_id_ex and br_taken are ignored. A redirect held in the frozen EX stage is acted on in the first cycle after release.
  - (2) br_taken: flush_if_id = flush_id_ex = 1. load_use is suppressed.
  - (3) load_use: stall_pc = stall_if_id = bubble_id_ex = 1, for exactly one cycle per hazard.
  - (4) Otherwise all control outputs are 0.
- Forwarding is combinational, applied per operand (ex_rs1 → fwd_a, ex_rs2 → fwd_b):
  - 01 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rsN;
  - else 10 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rsN;
  - else 00.
  - EX/MEM wins over WB. Register x0 never forwards.
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when mem_stall is 1; wait_cnt is cleared to 1.
  - MEM_WAIT → RUN when mem_ready is 1.
  - While mem_stall is 1 in MEM_WAIT, wait_cnt increments, saturating at MEM_TIMEOUT.
  - mem_err sets one cycle after wait_cnt reaches MEM_TIMEOUT. It stays set until reset. The FSM keeps waiting.
  - If mem_req drops while in MEM_WAIT, the FSM returns to RUN.
- Counters:
  - stall_cycles +1 on every cycle with stall_pc = 1.
  - flush_count +1 on every cycle with flush_id_ex = 1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
- Reset (synchronous):
  - Next-cycle state: FSM = RUN, wait_cnt = 0, mem_err = 0, both counters = 0.
  - While reset is high, every combinational control output is forced to 0, with fwd_a = fwd_b = 00.
  - Reset asserted during MEM_WAIT abandons the wait.
- Latency: control and forwarding outputs have zero-cycle latency. Status outputs (mem_err, counters) update one cycle after the event.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e: FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_WB = 2'b10;
  - mem_state_e: RUN, MEM_WAIT;
  - a struct for the registered status (state, wait_cnt, mem_err).
- One sub-module, sat_counter, parametrised by width with inc and clear inputs. It is instantiated twice, for stall_cycles and flush_count.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 → stall_pc, stall_if_id and bubble_id_ex are 1 for 1 cycle, then stall_cycles=1. Repeating with ex_rd=0 → no stall.
- Forwarding priority: ex_rs1=3 with mem_rd=3 & mem_reg_write=1 and wb_rd=3 & wb_reg_write=1 → fwd_a=01. With mem_reg_write=0 → fwd_a=10. With ex_rs2=0 and all writers targeting x0 → fwd_b=00.
- Branch vs load-use: br_taken=1 and load_use=1 together → flush_if_id = flush_id_ex = 1, stall_pc=0, flush_count=1 the next cycle.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → hold_ex and bubble_mem_wb are 1 for 3 cycles, FSM returns to RUN, stall_cycles=3. A concurrent br_taken is deferred until the 4th cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0 for 10 cycles → mem_err rises after cycle 4 and stays 1 after mem_ready. Reset clears it the next cycle.
- Saturation and reset: CNT_W=3, 9 stall cycles → stall_cycles=7. reset=1 for one cycle → all counters 0 and outputs 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forwarding selects,
// memory-wait FSM states and the registered status bundle.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_WB    = 2'b10
    } fwd_sel_e;

    // Encodings kept as plain constants so older code that compares raw bits still matches.
    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_WAIT = 1'b1;

    typedef enum logic {
        RUN      = ST_RUN,
        MEM_WAIT = ST_MEM_WAIT
    } mem_state_e;

    // Wide enough for any practical timeout; the counter saturates at MEM_TIMEOUT.
    localparam int WAIT_CNT_W = 16;

    typedef struct packed {
        mem_state_e            state;
        logic [WAIT_CNT_W-1:0] wait_cnt;
        logic                  mem_err;
    } mem_status_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: forwarding selects,
// load-use stalls, redirect flushes, memory-wait freeze with timeout, and perf counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  br_taken,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  hold_ex,
    output logic                  bubble_mem_wb,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    logic        mem_stall;
    logic        load_use;
    logic        ex_writes_unused;
    fwd_sel_e    fwd_a_sel;
    fwd_sel_e    fwd_b_sel;
    mem_status_t status_q;
    mem_status_t status_d;

    assign mem_stall = mem_req & ~mem_ready;

    // A load in EX produces its value too late for the dependent instruction in ID.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    // ex_reg_write is part of the EX bundle but hazards here are driven by ex_mem_read.
    assign ex_writes_unused = ex_reg_write;

    always_comb begin
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;
        if (!reset) begin
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
                fwd_a_sel = FWD_EXMEM;
            end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
                fwd_a_sel = FWD_WB;
            end
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
                fwd_b_sel = FWD_EXMEM;
            end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
                fwd_b_sel = FWD_WB;
            end
        end
    end

    assign fwd_a = fwd_a_sel;
    assign fwd_b = fwd_b_sel;

    // Memory wait freezes everything, so a redirect sitting in EX waits until release.
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        bubble_id_ex  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        hold_ex       = 1'b0;
        bubble_mem_wb = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                hold_ex       = 1'b1;
                bubble_mem_wb = 1'b1;
            end else if (br_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        status_d = status_q;
        unique case (status_q.state)
            RUN: begin
                if (mem_stall) begin
                    status_d.state    = MEM_WAIT;
                    status_d.wait_cnt = WAIT_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    status_d.state    = RUN;
                    status_d.wait_cnt = '0;
                end else if (status_q.wait_cnt != TIMEOUT_CNT) begin
                    status_d.wait_cnt = status_q.wait_cnt + WAIT_CNT_W'(1);
                end
            end
            default: begin
                status_d.state    = RUN;
                status_d.wait_cnt = '0;
            end
        endcase
        // Error is sticky and only flags the condition; the FSM keeps waiting.
        if ((status_q.state == MEM_WAIT) && (status_q.wait_cnt == TIMEOUT_CNT)) begin
            status_d.mem_err = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            status_q <= '{state: RUN, wait_cnt: '0, mem_err: 1'b0};
        end else begin
            status_q <= status_d;
        end
    end

    assign mem_err = status_q.mem_err;

    sat_counter #(.WIDTH(CNT_W)) u_stall_counter (
        .clock (clock),
        .clear (reset),
        .inc   (stall_pc),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_counter (
        .clock (clock),
        .clear (reset),
        .inc   (flush_id_ex),
        .count (flush_count)
    );

endmodule
